r4_delay_commutator: RTL

- Parametrised radix-4 multi-path delay commutator for the MDC FFT pipeline.
- Sits between a HADAMARD twiddle stage and the next GEMM butterfly; one instance per stage.
- Carries the real and imaginary parts of a lane together in one packed word.
- Supersedes the fixed-stage, real/imag-split commutators. Adds runtime-selectable delay depth, bypass mode, a valid/ready input, start-of-frame marking and a flush/drain sequence.

---
 rtl/r4_delay_commutator.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/r4_delay_commutator.sv
`default_nettype none
// ============================================================================
// Module   : r4_delay_commutator
// Function : radix-4 MDC delay commutator, 4x4 segment transpose of D beats
// Revision : 1.0
// ============================================================================

module r4_delay_commutator #(
  parameter int DATA_W         = 32,
  parameter int MAX_DEPTH_LOG2 = 3,
  parameter int CFG_W          = $clog2(MAX_DEPTH_LOG2 + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CFG_W-1:0]    cfg_depth_log2_i,
  input  logic                cfg_bypass_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [4*DATA_W-1:0] in_data_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  output logic                out_sof_o,
  output logic [4*DATA_W-1:0] out_data_o,
  output logic                busy_o
);

  localparam int c_MAX_D = 1 << MAX_DEPTH_LOG2;
  localparam int c_CNT_W = MAX_DEPTH_LOG2 + 2;
  localparam int c_DRN_W = $clog2(7 * c_MAX_D);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_PRIME = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_BYP   = 3'd4;

  logic [2:0]          r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [c_DRN_W-1:0]  r_drain, w_drain_load;
  logic [CFG_W-1:0]    r_dl, w_dl, w_cfg_clamp;
  logic [CFG_W:0]      w_cfg_ext;
  logic                r_byp, w_byp, r_primed;
  logic                w_acc, w_adv, w_adv_d, w_drain_beat, w_wrap;
  logic [c_CNT_W-1:0]  w_d, w_3d, w_4d_m1;
  logic [1:0]          w_seg;

  logic [DATA_W-1:0]   w_lane_in [4];
  logic [DATA_W-1:0]   w_dly     [4];
  logic [DATA_W-1:0]   w_sw      [4];
  logic [DATA_W-1:0]   w_y       [4];
  logic [4*DATA_W-1:0] w_y_flat;

  // Configuration is taken live on the IDLE beat that starts a stream, latched afterwards.
  assign w_cfg_ext   = {1'b0, cfg_depth_log2_i};
  assign w_cfg_clamp = (w_cfg_ext > (CFG_W+1)'(MAX_DEPTH_LOG2)) ?
                       CFG_W'(MAX_DEPTH_LOG2) : cfg_depth_log2_i;
  assign w_dl  = (r_state == c_IDLE) ? w_cfg_clamp  : r_dl;
  assign w_byp = (r_state == c_IDLE) ? cfg_bypass_i : r_byp;

  assign w_d     = c_CNT_W'(1) << w_dl;
  assign w_3d    = (w_d << 1) + w_d;
  assign w_4d_m1 = (w_d << 2) - c_CNT_W'(1);  // modular: 4*D_max wraps to 0 first
  assign w_seg   = 2'(r_cnt >> w_dl);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_acc) w_state_nxt = cfg_bypass_i ? c_BYP : c_PRIME;
      c_PRIME: begin
        if (flush_i)                                        w_state_nxt = c_DRAIN;
        else if (w_acc && (r_cnt == w_3d - c_CNT_W'(1)))    w_state_nxt = c_RUN;
      end
      c_RUN:   if (flush_i) w_state_nxt = c_DRAIN;
      c_DRAIN: if (r_drain == c_DRN_W'(1)) w_state_nxt = c_IDLE;
      c_BYP:   if (flush_i) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o   = 1'b1;
    busy_o       = 1'b1;
    w_drain_beat = 1'b0;
    case (r_state)
      c_IDLE:  busy_o = 1'b0;
      c_DRAIN: begin
        in_ready_o   = 1'b0;
        w_drain_beat = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_acc   = in_valid_i && in_ready_o;
  assign w_adv   = w_acc || w_drain_beat;
  assign w_adv_d = w_adv && !w_byp;
  assign w_wrap  = (r_cnt == (w_byp ? c_CNT_W'(3) : w_4d_m1));
  assign w_cnt_nxt = w_adv ? (w_wrap ? '0 : r_cnt + c_CNT_W'(1)) : r_cnt;

  // Drain pads the current frame to 4D beats, then flushes the 3D pipeline.
  assign w_drain_load = c_DRN_W'((c_CNT_W'(0) - w_cnt_nxt) & w_4d_m1) + c_DRN_W'(w_3d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_drain  <= '0;
      r_dl     <= '0;
      r_byp    <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && w_acc) begin
        r_dl  <= w_cfg_clamp;
        r_byp <= cfg_bypass_i;
      end
      if (w_state_nxt == c_IDLE) begin
        r_cnt    <= '0;
        r_primed <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_adv_d && (r_cnt == w_3d - c_CNT_W'(1))) r_primed <= 1'b1;
      end
      if ((r_state != c_DRAIN) && (w_state_nxt == c_DRAIN)) r_drain <= w_drain_load;
      else if (w_drain_beat)                                r_drain <= r_drain - c_DRN_W'(1);
    end
  end

  for (genvar gl = 0; gl < 4; gl++) begin : g_lane
    assign w_lane_in[gl] = w_drain_beat ? '0 : in_data_i[gl*DATA_W +: DATA_W];
    assign w_sw[gl]      = w_dly[w_seg - 2'(gl)];
    assign w_y_flat[gl*DATA_W +: DATA_W] = w_y[gl];
  end

  assign w_dly[0] = w_lane_in[0];

  // Input lane i is delayed i*D beats; storage sized for D_max, tap follows D.
  for (genvar gi = 1; gi < 4; gi++) begin : g_in_dly
    localparam int c_LEN = gi * c_MAX_D;
    localparam int c_IW  = $clog2(c_LEN);
    logic [DATA_W-1:0] r_sr [c_LEN];
    logic [c_IW-1:0]   w_tap;

    assign w_tap = c_IW'((gi << w_dl) - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < c_LEN; k++) r_sr[k] <= '0;
      end else if (w_adv_d) begin
        r_sr[0] <= w_lane_in[gi];
        for (int k = 1; k < c_LEN; k++) r_sr[k] <= r_sr[k-1];
      end
    end

    assign w_dly[gi] = r_sr[w_tap];
  end

  // Output lane j is delayed (3-j)*D beats after the rotating switch.
  for (genvar gj = 0; gj < 3; gj++) begin : g_out_dly
    localparam int c_LEN = (3 - gj) * c_MAX_D;
    localparam int c_IW  = $clog2(c_LEN);
    logic [DATA_W-1:0] r_sr [c_LEN];
    logic [c_IW-1:0]   w_tap;

    assign w_tap = c_IW'(((3 - gj) << w_dl) - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < c_LEN; k++) r_sr[k] <= '0;
      end else if (w_adv_d) begin
        r_sr[0] <= w_sw[gj];
        for (int k = 1; k < c_LEN; k++) r_sr[k] <= r_sr[k-1];
      end
    end

    assign w_y[gj] = r_sr[w_tap];
  end

  assign w_y[3] = w_sw[3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_sof_o   <= 1'b0;
      out_data_o  <= '0;
    end else begin
      out_valid_o <= 1'b0;
      out_sof_o   <= 1'b0;
      if (w_adv && w_byp) begin
        out_valid_o <= 1'b1;
        out_sof_o   <= (r_cnt == '0);
        out_data_o  <= in_data_i;
      end else if (w_adv_d && r_primed) begin
        out_valid_o <= 1'b1;
        out_sof_o   <= (r_cnt == w_3d);
        out_data_o  <= w_y_flat;
      end
    end
  end

endmodule

`default_nettype wire
